// File: rtl/uart_tx_param_if.sv
// Upstream valid/ready word handshake into the UART transmitter FIFO.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered words serialised LSB first, idle-high line.
// state  | meaning
// IDLE   | line at mark, waiting for a queued word
// START  | start bit (0)
// DATA   | data bits, shift_reg[0] on the line
// PARITY | parity of the word captured at pop
// STOP   | STOP_BITS mark bits, then pop next word or idle
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rstn,
    uart_tx_param_if.slave                     s_tx,
    output logic                               serial_out,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
            $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]        r_count;
    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par, r_tx, r_busy;
    logic [BW-1:0]        r_baud;
    logic [IW-1:0]        r_idx;

    logic [DATA_BITS-1:0] w_head;
    logic                 w_ready, w_push, w_bit_end, w_last_stop, w_pop;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_ready     = r_count < CW'(FIFO_DEPTH);
    assign w_push      = s_tx.tx_valid && w_ready;
    assign w_bit_end   = r_baud == BW'(CLKS_PER_BIT - 1);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_idx == IW'(STOP_BITS - 1));
    assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || w_last_stop);

    assign s_tx.tx_ready = w_ready;
    assign serial_out    = r_tx;
    assign busy          = r_busy;
    assign fifo_count    = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_tx.tx_data;
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_baud  <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else if (w_pop) begin
            r_state <= S_START;
            r_shift <= w_head;
            r_par   <= (^w_head) ^ (PARITY == 1);
            r_baud  <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            if (r_state != S_IDLE) r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
            if (w_bit_end) begin
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                    end
                    S_DATA: begin
                        if (r_idx == IW'(DATA_BITS - 1)) begin
                            r_idx <= '0;
                            if (PARITY != 0) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
                    S_STOP: begin
                        if (r_idx == IW'(STOP_BITS - 1)) begin
                            r_state <= S_IDLE;
                            r_idx   <= '0;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameter variants sharing clk/rstn, line checked every cycle.
module tb_uart_tx_param;
    localparam int CPB = 4;

    logic       clk;
    logic       rstn;
    logic [8:0] drv_data [4];
    logic [3:0] drv_valid;
    logic [8:0] wl [8];
    wire  [3:0] so;
    wire  [3:0] bsy;
    wire  [3:0] rdy;
    wire  [11:0] fcv;
    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_param_if #(.DATA_BITS(8)) if_a ();
    uart_tx_param_if #(.DATA_BITS(8)) if_b ();
    uart_tx_param_if #(.DATA_BITS(8)) if_c ();
    uart_tx_param_if #(.DATA_BITS(5)) if_d ();

    assign if_a.tx_data  = drv_data[0][7:0];
    assign if_b.tx_data  = drv_data[1][7:0];
    assign if_c.tx_data  = drv_data[2][7:0];
    assign if_d.tx_data  = drv_data[3][4:0];
    assign if_a.tx_valid = drv_valid[0];
    assign if_b.tx_valid = drv_valid[1];
    assign if_c.tx_valid = drv_valid[2];
    assign if_d.tx_valid = drv_valid[3];
    assign rdy = {if_d.tx_ready, if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};

    uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4))
        u_dut_a (.clk(clk), .rstn(rstn), .s_tx(if_a), .serial_out(so[0]), .busy(bsy[0]), .fifo_count(fcv[2:0]));
    uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4))
        u_dut_b (.clk(clk), .rstn(rstn), .s_tx(if_b), .serial_out(so[1]), .busy(bsy[1]), .fifo_count(fcv[5:3]));
    uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4))
        u_dut_c (.clk(clk), .rstn(rstn), .s_tx(if_c), .serial_out(so[2]), .busy(bsy[2]), .fifo_count(fcv[8:6]));
    uart_tx_param #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4))
        u_dut_d (.clk(clk), .rstn(rstn), .s_tx(if_d), .serial_out(so[3]), .busy(bsy[3]), .fifo_count(fcv[11:9]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected line level at bit position pos of a frame (0 = start).
    function automatic logic exp_bit(input logic [8:0] w, input int dbits, input int par, input int pos);
        logic [8:0] m;
        logic       p;
        m = 9'((1 << dbits) - 1);
        p = ^(w & m);
        if (pos == 0) return 1'b0;
        if (pos <= dbits) return w[pos-1];
        if (par != 0 && pos == dbits + 1) return (par == 2) ? p : ~p;
        return 1'b1;
    endfunction

    task automatic push_words(input int idx, input int n, input bit bp);
        int   k = 0;
        int   cyc = 0;
        logic took;
        bit   full_seen = 0;
        bit   rose = 0;
        @(negedge clk);
        drv_data[idx]  = wl[0];
        drv_valid[idx] = 1'b1;
        while (k < n && cyc < 300) begin
            took = rdy[idx];
            @(posedge clk);
            cyc++;
            #1;
            if (took) begin
                k++;
                if (k < n) drv_data[idx] = wl[k];
                else       drv_valid[idx] = 1'b0;
            end
            @(negedge clk);
            if (bp && k == 5 && !full_seen) begin
                full_seen = 1;
                chk("bp_full_edge", cyc, 5);
                chk("bp_count_full", 32'(fcv[idx*3 +: 3]), 4);
                chk("bp_ready_low", 32'(rdy[idx]), 0);
            end
            if (bp && full_seen && !rose && rdy[idx]) begin
                rose = 1;
                chk("bp_ready_rise_edge", cyc, 42);
            end
        end
        drv_valid[idx] = 1'b0;
        chk("all_words_pushed", k, n);
    endtask

    task automatic watch(input int idx, input int n, input int dbits, input int par, input int stops);
        int len;
        int pos;
        len = CPB * (1 + dbits + ((par != 0) ? 1 : 0) + stops);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("d%0d_line_idle_after_push", idx), 32'(so[idx]), 1);
        chk($sformatf("d%0d_fifo_count_after_push", idx), 32'(fcv[idx*3 +: 3]), 1);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                pos = c / CPB;
                chk($sformatf("d%0d_frame%0d_bit%0d_cyc%0d", idx, f, pos, c), 32'(so[idx]),
                    32'(exp_bit(wl[f], dbits, par, pos)));
                chk($sformatf("d%0d_busy_frame%0d", idx, f), 32'(bsy[idx]), 1);
            end
        end
        @(negedge clk);
        chk($sformatf("d%0d_line_idle_end", idx), 32'(so[idx]), 1);
        chk($sformatf("d%0d_busy_end", idx), 32'(bsy[idx]), 0);
    endtask

    task automatic run(input int idx, input int n, input int dbits, input int par, input int stops, input bit bp);
        fork
            push_words(idx, n, bp);
            watch(idx, n, dbits, par, stops);
        join
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        drv_valid = '0;
        for (int i = 0; i < 4; i++) drv_data[i] = '0;
        for (int i = 0; i < 8; i++) wl[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_serial", 32'(so), 32'hF);
        chk("reset_busy", 32'(bsy), 0);
        chk("reset_fifo_count", 32'(fcv), 0);
        chk("reset_ready", 32'(rdy), 32'hF);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_serial", 32'(so), 32'hF);

        wl[0] = 9'h0A5;
        run(0, 1, 8, 0, 1, 0);

        wl[0] = 9'h007;
        run(1, 1, 8, 2, 1, 0);
        run(2, 1, 8, 1, 1, 0);
        wl[0] = 9'h0A5;
        run(1, 1, 8, 2, 1, 0);

        wl[0] = 9'h013;
        run(3, 1, 5, 0, 2, 0);

        wl[0] = 9'h011; wl[1] = 9'h022; wl[2] = 9'h033;
        wl[3] = 9'h044; wl[4] = 9'h055; wl[5] = 9'h066;
        run(0, 6, 8, 0, 1, 1);

        wl[0] = 9'h081; wl[1] = 9'h0C3; wl[2] = 9'h00F;
        run(0, 3, 8, 0, 1, 0);

        // Reset during data bit 3 of the first word with two words still queued.
        @(negedge clk);
        drv_data[0] = 9'h0F0;
        drv_valid[0] = 1'b1;
        @(posedge clk); #1;
        drv_data[0] = 9'h0AA;
        @(posedge clk); #1;
        drv_data[0] = 9'h055;
        @(posedge clk); #1;
        drv_valid[0] = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        chk("pre_reset_data_bit3", 32'(so[0]), 0);
        chk("pre_reset_fifo_count", 32'(fcv[2:0]), 2);
        rstn = 1'b0;
        #1;
        chk("midreset_serial", 32'(so[0]), 1);
        chk("midreset_fifo_count", 32'(fcv[2:0]), 0);
        chk("midreset_busy", 32'(bsy[0]), 0);
        chk("midreset_ready", 32'(rdy[0]), 1);
        @(negedge clk);
        rstn = 1'b1;
        wl[0] = 9'h05A;
        run(0, 1, 8, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
